logic_gate_bank_reg: RTL and testbench

Parametrised, registered successor to the 3-gate 2-input OR package model.
- Provides WIDTH independent 2-input gate channels.
- A run-time MODE selects the channel function: OR, NOR, AND, NAND, XOR, XNOR, pass-A, or sticky OR-accumulate.
- Results pass through a STAGES-deep clock-enabled pipeline with a valid flag, and drive a tri-state output bus.
- Used as a drop-in glue-logic bank wherever registered 74-series gate/latch combinations (gate followed by a '574-style register) are modelled.

---
 rtl/logic_gate_bank_reg.sv | 110 +++++++++++
 tb/tb_logic_gate_bank_reg.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/logic_gate_bank_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : logic_gate_bank_reg
// Purpose  : WIDTH-channel bank of 2-input gates with a run-time selectable
//            function (OR/NOR/AND/NAND/XOR/XNOR/pass-A/OR-accumulate),
//            followed by a STAGES-deep clock-enabled output pipeline with a
//            valid flag and a tri-state result bus.
// Ports    : CLK      rising-edge clock
//            CLR_n    asynchronous active-low reset
//            A, B     operands, one bit per channel (bit 0 = gate 1)
//            MODE     function select
//            CE       clock enable; low freezes every register
//            VIN      input sample valid (qualifies VOUT and accumulator)
//            ACC_CLR  synchronous accumulator clear
//            OE_n     active-low output enable for Y
//            Y        registered result, high-Z while OE_n=1
//            VOUT     valid flag aligned with Y (always driven)
// Revision : 1.0 - initial release
// ============================================================================
module logic_gate_bank_reg #(
  parameter int WIDTH  = 3,
  parameter int STAGES = 1
) (
  input  logic             CLK,
  input  logic             CLR_n,
  input  logic [0:WIDTH-1] A,
  input  logic [0:WIDTH-1] B,
  input  logic [2:0]       MODE,
  input  logic             CE,
  input  logic             VIN,
  input  logic             ACC_CLR,
  input  logic             OE_n,
  output logic [0:WIDTH-1] Y,
  output logic             VOUT
);

  localparam logic [2:0] MODE_OR   = 3'b000;
  localparam logic [2:0] MODE_NOR  = 3'b001;
  localparam logic [2:0] MODE_AND  = 3'b010;
  localparam logic [2:0] MODE_NAND = 3'b011;
  localparam logic [2:0] MODE_XOR  = 3'b100;
  localparam logic [2:0] MODE_XNOR = 3'b101;
  localparam logic [2:0] MODE_ACC  = 3'b110;

  logic [0:WIDTH-1] acc_q;
  logic [0:WIDTH-1] acc_d;
  logic [0:WIDTH-1] stage1_d;
  logic [0:WIDTH-1] data_q [STAGES];
  logic [0:STAGES-1] vld_q;

  // Accumulator next state. A clear coinciding with a valid accumulate
  // sample restarts the accumulation from that sample rather than from 0.
  always_comb begin
    acc_d = acc_q;
    if (ACC_CLR) begin
      if (MODE == MODE_ACC && VIN) acc_d = A | B;
      else                         acc_d = '0;
    end else if (MODE == MODE_ACC && VIN) begin
      acc_d = acc_q | A | B;
    end
  end

  // Gate function feeding stage 1. Accumulate mode shows the value the
  // accumulator takes on this same edge.
  always_comb begin
    stage1_d = A;
    case (MODE)
      MODE_OR:   stage1_d = A | B;
      MODE_NOR:  stage1_d = ~(A | B);
      MODE_AND:  stage1_d = A & B;
      MODE_NAND: stage1_d = ~(A & B);
      MODE_XOR:  stage1_d = A ^ B;
      MODE_XNOR: stage1_d = ~(A ^ B);
      MODE_ACC:  stage1_d = acc_d;
      default:   stage1_d = A;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      acc_q     <= '0;
      data_q[0] <= '0;
      vld_q[0]  <= 1'b0;
    end else if (CE) begin
      acc_q     <= acc_d;
      data_q[0] <= stage1_d;
      vld_q[0]  <= VIN;
    end
  end

  generate
    for (genvar k = 1; k < STAGES; k++) begin : g_stage
      always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
          data_q[k] <= '0;
          vld_q[k]  <= 1'b0;
        end else if (CE) begin
          data_q[k] <= data_q[k-1];
          vld_q[k]  <= vld_q[k-1];
        end
      end
    end
  endgenerate

  assign Y    = OE_n ? {WIDTH{1'bz}} : data_q[STAGES-1];
  assign VOUT = vld_q[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_logic_gate_bank_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_logic_gate_bank_reg
// Purpose  : Self-checking bench for logic_gate_bank_reg. Three instances
//            (STAGES = 1, 2, 4) share one stimulus stream; a reference model
//            pushes one expected output per enabled edge into a per-instance
//            queue and a monitor pops and compares on the falling edge.
//            The Y buses are pulled high so a released bus reads all ones.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_gate_bank_reg;

  localparam int W = 3;

  typedef struct packed {
    logic         v;
    logic [0:W-1] y;
  } exp_t;

  logic         CLK = 1'b0;
  logic         CLR_n = 1'b0;
  logic [0:W-1] A = '0;
  logic [0:W-1] B = '0;
  logic [2:0]   MODE = 3'b000;
  logic         CE = 1'b0;
  logic         VIN = 1'b0;
  logic         ACC_CLR = 1'b0;
  logic         OE_n = 1'b0;

  tri1 [0:W-1] y1;
  tri1 [0:W-1] y2;
  tri1 [0:W-1] y4;
  logic        v1, v2, v4;

  logic_gate_bank_reg #(.WIDTH(W), .STAGES(1)) u_s1 (
    .CLK(CLK), .CLR_n(CLR_n), .A(A), .B(B), .MODE(MODE), .CE(CE), .VIN(VIN),
    .ACC_CLR(ACC_CLR), .OE_n(OE_n), .Y(y1), .VOUT(v1));
  logic_gate_bank_reg #(.WIDTH(W), .STAGES(2)) u_s2 (
    .CLK(CLK), .CLR_n(CLR_n), .A(A), .B(B), .MODE(MODE), .CE(CE), .VIN(VIN),
    .ACC_CLR(ACC_CLR), .OE_n(OE_n), .Y(y2), .VOUT(v2));
  logic_gate_bank_reg #(.WIDTH(W), .STAGES(4)) u_s4 (
    .CLK(CLK), .CLR_n(CLR_n), .A(A), .B(B), .MODE(MODE), .CE(CE), .VIN(VIN),
    .ACC_CLR(ACC_CLR), .OE_n(OE_n), .Y(y4), .VOUT(v4));

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  exp_t q1[$];
  exp_t q2[$];
  exp_t q4[$];
  exp_t cur1 = '0;
  exp_t cur2 = '0;
  exp_t cur4 = '0;
  logic [0:W-1] m_acc = '0;
  bit edge_pend = 1'b0;

  // Spec-level function of one sample; acc_new is the accumulator value
  // after this edge's update.
  function automatic logic [0:W-1] gate_f(input logic [2:0] m,
                                          input logic [0:W-1] a,
                                          input logic [0:W-1] b,
                                          input logic [0:W-1] acc_new);
    case (m)
      3'd0: return a | b;
      3'd1: return ~(a | b);
      3'd2: return a & b;
      3'd3: return ~(a & b);
      3'd4: return a ^ b;
      3'd5: return ~(a ^ b);
      3'd6: return acc_new;
      default: return a;
    endcase
  endfunction

  // Reference model: a queue per instance holds what is in flight. It is
  // primed with STAGES-1 zero entries so that one push plus one pop per
  // enabled edge yields the value now at the output.
  always @(posedge CLK or negedge CLR_n) begin : model
    logic [0:W-1] nacc;
    exp_t e;
    if (!CLR_n) begin
      m_acc = '0;
      q1.delete();
      q2.delete();
      q4.delete();
      q2.push_back('0);
      for (int i = 0; i < 3; i++) q4.push_back('0);
      cur1 = '0;
      cur2 = '0;
      cur4 = '0;
      edge_pend = 1'b0;
    end else if (CE) begin
      nacc = m_acc;
      if (ACC_CLR)                  nacc = (MODE == 3'd6 && VIN) ? (A | B) : '0;
      else if (MODE == 3'd6 && VIN) nacc = m_acc | A | B;
      m_acc = nacc;
      e.v = VIN;
      e.y = gate_f(MODE, A, B, nacc);
      q1.push_back(e);
      q2.push_back(e);
      q4.push_back(e);
      edge_pend = 1'b1;
    end
  end

  task automatic check(input string nm, input exp_t e, input logic v,
                       input logic [0:W-1] y);
    logic [0:W-1] ey;
    ey = OE_n ? '1 : e.y;
    checks++;
    if (v !== e.v) begin
      errors++;
      $display("FAIL %s_vout t=%0t got=%b exp=%b", nm, $time, v, e.v);
    end
    checks++;
    if (y !== ey) begin
      errors++;
      $display("FAIL %s_y t=%0t got=%b exp=%b oe_n=%b", nm, $time, y, ey, OE_n);
    end
  endtask

  task automatic pop_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s_queue t=%0t got=empty exp=entry", nm, $time);
  endtask

  always @(negedge CLK) begin : monitor
    if (edge_pend) begin
      edge_pend = 1'b0;
      if (q1.size() == 0) pop_fail("s1"); else cur1 = q1.pop_front();
      if (q2.size() == 0) pop_fail("s2"); else cur2 = q2.pop_front();
      if (q4.size() == 0) pop_fail("s4"); else cur4 = q4.pop_front();
    end
    check("s1", cur1, v1, y1);
    check("s2", cur2, v2, y2);
    check("s4", cur4, v4, y4);
  end

  task automatic drive(input logic [2:0] m, input logic [0:W-1] a,
                       input logic [0:W-1] b, input logic ce, input logic vin,
                       input logic aclr, input logic oe_n);
    @(negedge CLK);
    #2;
    MODE = m; A = a; B = b; CE = ce; VIN = vin; ACC_CLR = aclr; OE_n = oe_n;
  endtask

  initial begin
    logic [0:W-1] pa [4];
    logic [0:W-1] pb [4];
    logic [2:0]   modes [7];
    pa[0] = 3'b100; pb[0] = 3'b100;
    pa[1] = 3'b000; pb[1] = 3'b100;
    pa[2] = 3'b100; pb[2] = 3'b000;
    pa[3] = 3'b000; pb[3] = 3'b000;
    modes[0] = 3'd0; modes[1] = 3'd1; modes[2] = 3'd2; modes[3] = 3'd3;
    modes[4] = 3'd4; modes[5] = 3'd5; modes[6] = 3'd7;

    // Reset held across several edges; outputs read zero.
    repeat (3) @(posedge CLK);
    #1;
    check("rst_s1", '0, v1, y1);
    check("rst_s2", '0, v2, y2);
    check("rst_s4", '0, v4, y4);
    @(negedge CLK);
    #2;
    CLR_n = 1'b1;

    // OR truth table per gate, patterns shifted through each channel.
    for (int sh = 0; sh < W; sh++)
      for (int p = 0; p < 4; p++)
        drive(3'd0, pa[p] >> sh, pb[p] >> sh, 1'b1, 1'b1, 1'b0, 1'b0);

    // Every non-accumulate mode on A=110, B=011.
    for (int i = 0; i < 7; i++)
      drive(modes[i], 3'b110, 3'b011, 1'b1, 1'b1, 1'b0, 1'b0);

    // Accumulate with fresh start, then clear alone.
    drive(3'd6, 3'b100, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(3'd6, 3'b000, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(3'd6, 3'b001, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(3'd6, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(3'd6, 3'b010, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);

    // Clock enable low for three cycles with changing operands.
    for (int i = 0; i < 3; i++)
      drive(3'd0, W'(i + 3), W'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    // Accumulate mode with VIN low leaves the accumulator alone.
    drive(3'd6, 3'b111, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    // Leaving and re-entering accumulate resumes from the held value.
    drive(3'd2, 3'b111, 3'b101, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(3'd6, 3'b000, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0);

    // Output enable released while VIN toggles, then restored.
    for (int i = 0; i < 5; i++)
      drive(3'd2, 3'b101, 3'b100, 1'b1, 1'(i % 2), 1'b0, 1'b1);
    drive(3'd2, 3'b101, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(3'd2, 3'b101, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0);

    // Fill every pipeline with 111, then reset between edges.
    for (int i = 0; i < 5; i++)
      drive(3'd0, 3'b111, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    #2;
    CLR_n = 1'b0;
    #1;
    check("async_s1", '0, v1, y1);
    check("async_s2", '0, v2, y2);
    check("async_s4", '0, v4, y4);
    @(negedge CLK);
    #2;
    CLR_n = 1'b1;
    for (int i = 0; i < 5; i++)
      drive(3'd5, 3'b011, 3'b110, 1'b1, 1'b1, 1'b0, 1'b0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      drive(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom),
            1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) == 0));

    // Drain.
    for (int i = 0; i < 6; i++)
      drive(3'd0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
